// File: rtl/keccak_pkg.sv
// Shared keccak sponge parameters, pad constants and front-end state encoding.
// The size helpers let each instance derive its own rate from l and d.
package keccak_pkg;

    localparam int L_DEF = 6;
    localparam int D_DEF = 112;

    function automatic int b_of(input int l);
        return 25 << l;
    endfunction

    function automatic int c_of(input int d);
        return 2 * d;
    endfunction

    function automatic int r_bytes_of(input int l, input int d);
        return (b_of(l) - c_of(d)) / 8;
    endfunction

    localparam int B       = b_of(L_DEF);
    localparam int C       = c_of(D_DEF);
    localparam int R_BYTES = r_bytes_of(L_DEF, D_DEF);
    localparam int R       = 8 * R_BYTES;

    localparam logic [7:0] PAD_FINAL = 8'h80;
    localparam logic [7:0] DS_SHA3   = 8'h06;
    localparam logic [7:0] DS_SHAKE  = 8'h1F;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        PAD  = 2'd2
    } state_e;

endpackage

// File: rtl/keccak_pad_lane.sv
// One byte lane of the rate accumulator: optional write of the incoming
// byte, then optional XOR of the domain byte and of the final pad bit.
module keccak_pad_lane
    import keccak_pkg::*;
(
    input  logic [7:0] cur_i,
    input  logic [7:0] data_i,
    input  logic [7:0] ds_i,
    input  logic       wr_en_i,
    input  logic       ds_en_i,
    input  logic       fin_en_i,
    output logic [7:0] nxt_o
);

    always_comb begin
        nxt_o = wr_en_i ? data_i : cur_i;
        if (ds_en_i) begin
            nxt_o = nxt_o ^ ds_i;
        end
        if (fin_en_i) begin
            nxt_o = nxt_o ^ PAD_FINAL;
        end
    end

endmodule

// File: rtl/keccak_pad.sv
// Byte-stream packer for the keccak sponge: fills r-bit rate blocks,
// applies pad10*1 with a domain byte and flags the final block.
module keccak_pad
    import keccak_pkg::*;
#(
    parameter int         l       = 6,
    parameter int         d       = 112,
    parameter int         R_BYTES = r_bytes_of(l, d),
    parameter logic [7:0] DS_BYTE = DS_SHA3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_keep,
    input  logic                 in_last,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [8*R_BYTES-1:0] blk_data,
    output logic                 blk_last
);

    localparam int RW = 8 * R_BYTES;
    localparam int CW = $clog2(R_BYTES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(R_BYTES);
    localparam logic [RW-1:0] PAD_BLK  =
        {PAD_FINAL, {(RW - 16){1'b0}}, DS_BYTE};

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_d;
    logic            last_q;
    logic            pend_q;
    logic            in_ready_q;
    logic            blk_valid_q;

    logic            fire;
    logic            wr;
    logic [CW-1:0]   m;
    logic            pad_now;

    assign fire    = in_valid & in_ready_q & (state_q == FILL);
    assign wr      = fire & in_keep;
    assign m       = cnt_q + CW'(wr);
    // Pad lands in this block only if the tail left room for it.
    assign pad_now = fire & in_last & (m < CNT_FULL);

    for (genvar k = 0; k < R_BYTES; k++) begin : g_lane
        keccak_pad_lane u_lane (
            .cur_i    (acc_q[8*k +: 8]),
            .data_i   (in_data),
            .ds_i     (DS_BYTE),
            .wr_en_i  (wr && (cnt_q == CW'(k))),
            .ds_en_i  (pad_now && (m == CW'(k))),
            .fin_en_i (pad_now && (k == R_BYTES - 1)),
            .nxt_o    (acc_d[8*k +: 8])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            acc_q       <= '0;
            last_q      <= 1'b0;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q  <= 1'b1;
                    blk_valid_q <= 1'b0;
                    if (fire) begin
                        acc_q <= acc_d;
                        if (in_last) begin
                            cnt_q       <= '0;
                            last_q      <= pad_now;
                            pend_q      <= ~pad_now;
                            state_q     <= FULL;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                        end else if (m == CNT_FULL) begin
                            cnt_q       <= '0;
                            last_q      <= 1'b0;
                            state_q     <= FULL;
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= m;
                        end
                    end
                end
                FULL: begin
                    if (blk_ready) begin
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        last_q      <= 1'b0;
                        blk_valid_q <= 1'b0;
                        in_ready_q  <= ~pend_q;
                        state_q     <= pend_q ? PAD : FILL;
                    end
                end
                PAD: begin
                    acc_q       <= PAD_BLK;
                    last_q      <= 1'b1;
                    pend_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    blk_valid_q <= 1'b1;
                    state_q     <= FULL;
                end
                default: begin
                    state_q     <= FILL;
                    in_ready_q  <= 1'b0;
                    blk_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = acc_q;
    assign blk_last  = last_q;

endmodule

// File: tb/tb_keccak_pad.sv
// Directed bench for keccak_pad: table of messages with hand-derived blocks
// plus hand sequences for backpressure, protocol error and mid-message reset.
module tb_keccak_pad;

    localparam int RB = 172;
    localparam int RW = 8 * RB;
    localparam logic [8:0] NONE = 9'h1FF;

    typedef struct packed {
        logic [8:0] nfill;
        logic [8:0] pos;
        logic [7:0] posv;
        logic [7:0] tailv;
        logic       last;
    } blk_exp_t;

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] inc;
        bit         ztail;
        int         nblk;
        blk_exp_t   e0;
        blk_exp_t   e1;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          in_keep = 1'b0;
    logic          in_last = 1'b0;
    logic          blk_valid;
    logic          blk_ready = 1'b1;
    logic [RW-1:0] blk_data;
    logic          blk_last;

    int total = 0;
    int bad = 0;

    logic [RW-1:0] qd[$];
    logic          ql[$];
    vec_t          tv[$];

    keccak_pad dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && blk_valid && blk_ready) begin
            qd.push_back(blk_data);
            ql.push_back(blk_last);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, req);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [RW-1:0] act,
                           input logic [RW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            for (int j = 0; j < RB; j++) begin
                if (act[8*j +: 8] !== req[8*j +: 8]) begin
                    $display("FAIL %s byte%0d got=%h want=%h",
                             nm, j, act[8*j +: 8], req[8*j +: 8]);
                    break;
                end
            end
        end
    endtask

    function automatic blk_exp_t ex(input int nf, input logic [8:0] p,
                                    input logic [7:0] pv, input logic [7:0] tl,
                                    input logic lst);
        blk_exp_t e;
        e.nfill = 9'(nf);
        e.pos   = p;
        e.posv  = pv;
        e.tailv = tl;
        e.last  = lst;
        return e;
    endfunction

    function automatic logic [RW-1:0] mk(input blk_exp_t e,
                                         input logic [7:0] base,
                                         input logic [7:0] inc, input int bi);
        logic [RW-1:0] r;
        logic [7:0]    v;
        r = '0;
        for (int j = 0; j < RB; j++) begin
            if (j < int'(e.nfill)) v = base + inc * 8'(bi * RB + j);
            else if (j == int'(e.pos)) v = e.posv;
            else if (j == RB - 1) v = e.tailv;
            else v = 8'h00;
            r[8*j +: 8] = v;
        end
        return r;
    endfunction

    task automatic addv(input int n, input logic [7:0] base,
                        input logic [7:0] inc, input bit zt, input int nb,
                        input blk_exp_t e0, input blk_exp_t e1);
        vec_t v;
        v.n = n;
        v.base = base;
        v.inc = inc;
        v.ztail = zt;
        v.nblk = nb;
        v.e0 = e0;
        v.e1 = e1;
        tv.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic beat(input logic [7:0] dat, input logic k, input logic lst);
        int g;
        in_valid = 1'b1;
        in_data  = dat;
        in_keep  = k;
        in_last  = lst;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout got=0 want=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_blocks(input int nb);
        for (int g = 0; g < 40 && qd.size() < nb; g++) @(negedge clk);
    endtask

    initial begin
        blk_exp_t none;
        blk_exp_t eb;
        logic [RW-1:0] want;
        none = ex(0, NONE, 8'h00, 8'h00, 1'b0);

        addv(0,   8'h00, 8'h00, 1'b1, 1, ex(0, 9'd0, 8'h06, 8'h80, 1'b1), none);
        addv(3,   8'h61, 8'h01, 1'b0, 1, ex(3, 9'd3, 8'h06, 8'h80, 1'b1), none);
        addv(171, 8'hA5, 8'h00, 1'b0, 1,
             ex(171, 9'd171, 8'h86, 8'h80, 1'b1), none);
        addv(172, 8'hA5, 8'h00, 1'b0, 2, ex(172, NONE, 8'h00, 8'h00, 1'b0),
             ex(0, 9'd0, 8'h06, 8'h80, 1'b1));
        addv(5,   8'h10, 8'h03, 1'b1, 1, ex(5, 9'd5, 8'h06, 8'h80, 1'b1), none);
        addv(170, 8'h00, 8'h01, 1'b0, 1,
             ex(170, 9'd170, 8'h06, 8'h80, 1'b1), none);
        addv(1,   8'hFF, 8'h00, 1'b0, 1, ex(1, 9'd1, 8'h06, 8'h80, 1'b1), none);
        addv(172, 8'h01, 8'h07, 1'b1, 2, ex(172, NONE, 8'h00, 8'h00, 1'b0),
             ex(0, 9'd0, 8'h06, 8'h80, 1'b1));

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(blk_valid), 0);
        chk("rst_last", 32'(blk_last), 0);
        chk_blk("rst_data", blk_data, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 1);

        foreach (tv[i]) begin
            qd.delete();
            ql.delete();
            for (int b = 0; b < tv[i].n; b++) begin
                beat(tv[i].base + tv[i].inc * 8'(b), 1'b1,
                     (b == tv[i].n - 1) && !tv[i].ztail);
            end
            if (tv[i].ztail) beat(8'h55, 1'b0, 1'b1);
            chk($sformatf("v%0d_lat", i), 32'(blk_valid), 1);
            wait_blocks(tv[i].nblk);
            chk($sformatf("v%0d_nblk", i), 32'(qd.size()), 32'(tv[i].nblk));
            for (int b = 0; b < tv[i].nblk && b < qd.size(); b++) begin
                eb = (b == 0) ? tv[i].e0 : tv[i].e1;
                chk_blk($sformatf("v%0d_b%0d_data", i, b), qd[b],
                        mk(eb, tv[i].base, tv[i].inc, b));
                chk($sformatf("v%0d_b%0d_last", i, b), 32'(ql[b]),
                    32'(eb.last));
            end
        end

        // Backpressure: block must hold for 5 cycles, then go on first ready.
        qd.delete();
        ql.delete();
        blk_ready = 1'b0;
        beat(8'h78, 1'b1, 1'b0);
        beat(8'h79, 1'b1, 1'b1);
        want = mk(ex(2, 9'd2, 8'h06, 8'h80, 1'b1), 8'h78, 8'h01, 0);
        for (int c = 0; c < 5; c++) begin
            chk_blk($sformatf("bp%0d_data", c), blk_data, want);
            chk($sformatf("bp%0d_vl", c),
                {29'd0, blk_valid, blk_last, in_ready}, 32'b110);
            @(negedge clk);
        end
        chk("bp_held", 32'(qd.size()), 0);
        blk_ready = 1'b1;
        @(negedge clk);
        chk("bp_taken", 32'(qd.size()), 1);
        if (qd.size() > 0) chk_blk("bp_blk", qd[0], want);
        chk("bp_free", 32'(blk_valid), 0);

        // keep=0 without last is dropped.
        qd.delete();
        ql.delete();
        @(negedge clk);
        beat(8'h61, 1'b1, 1'b0);
        beat(8'hEE, 1'b0, 1'b0);
        beat(8'h62, 1'b1, 1'b1);
        wait_blocks(1);
        chk("perr_nblk", 32'(qd.size()), 1);
        if (qd.size() > 0)
            chk_blk("perr_blk", qd[0],
                    mk(ex(2, 9'd2, 8'h06, 8'h80, 1'b1), 8'h61, 8'h01, 0));

        // Reset mid-message discards the partial block.
        qd.delete();
        ql.delete();
        @(negedge clk);
        for (int b = 0; b < 50; b++) beat(8'h33, 1'b1, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(blk_valid), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mrst_none", 32'(qd.size()) + 32'(blk_valid), 0);
        beat(8'h61, 1'b1, 1'b0);
        beat(8'h62, 1'b1, 1'b0);
        beat(8'h63, 1'b1, 1'b1);
        wait_blocks(1);
        chk("mrst_nblk", 32'(qd.size()), 1);
        if (qd.size() > 0) begin
            chk_blk("mrst_abc", qd[0],
                    mk(ex(3, 9'd3, 8'h06, 8'h80, 1'b1), 8'h61, 8'h01, 0));
            chk("mrst_last", 32'(ql[0]), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
